// File: rtl/locked_ripple_divider_pkg.sv
// Shared types for the key-locked ripple divider.
package locked_div_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } lock_state_e;

    localparam int FAIL_W = 2;

endpackage

// File: rtl/locked_ripple_divider_if.sv
// Control/status bundle of the locked divider: master drives en/key, slave returns counter status.
interface locked_ripple_divider_if
    import locked_div_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int KEY_W  = 8
);
    logic              en;
    logic [KEY_W-1:0]  key_in;
    logic              key_load;
    logic [STAGES-1:0] count;
    logic              div_out;
    logic              wrap;
    logic              unlocked;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output en, key_in, key_load,
        input  count, div_out, wrap, unlocked, fail_cnt
    );

    modport slave (
        input  en, key_in, key_load,
        output count, div_out, wrap, unlocked, fail_cnt
    );
endinterface

// File: rtl/locked_ripple_divider_lock_key_fsm.sv
// Key register, unlock FSM and failed-attempt counter; produces the counter corruption mask.
// DIV_KEY_LOCKOUT_EN adds a terminal LOCKOUT state after MAX_TRIES wrong keys.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  LOCKED   | wrong or no key, counter corrupted by key_reg ^ KEY
//  CHECK    | one cycle comparing the freshly captured key
//  UNLOCKED | correct key, counter runs clean
//  LOCKOUT  | too many wrong keys, mask all ones until reset (macro only)
module lock_key_fsm
    import locked_div_pkg::*;
#(
    parameter int               STAGES    = 4,
    parameter int               KEY_W     = 8,
    parameter logic [KEY_W-1:0] KEY       = 8'hA5,
    parameter int               MAX_TRIES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_load,
    output lock_state_e       state,
    output logic [STAGES-1:0] mask,
    output logic              unlocked,
    output logic [FAIL_W-1:0] fail_cnt
);

    lock_state_e       state_q, state_d;
    logic [KEY_W-1:0]  key_reg_q, key_reg_d;
    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;

    // State, key and fail-count registers; reset leaves an intentionally wrong key in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOCKED;
            key_reg_q  <= ~KEY;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            key_reg_q  <= key_reg_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Next-state logic: key capture, one-cycle check, saturating failure count
    always_comb begin
        state_d    = state_q;
        key_reg_d  = key_reg_q;
        fail_cnt_d = fail_cnt_q;
        case (state_q)
            LOCKED, UNLOCKED: begin
                if (key_load) begin
                    state_d   = CHECK;
                    key_reg_d = key_in;
                end
            end
            CHECK: begin
                if (key_reg_q == KEY) begin
                    state_d    = UNLOCKED;
                    fail_cnt_d = '0;
                end else begin
                    state_d = LOCKED;
                    if (fail_cnt_q != {FAIL_W{1'b1}}) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
`ifdef DIV_KEY_LOCKOUT_EN
                    if (int'(fail_cnt_q) + 1 >= MAX_TRIES) begin
                        state_d = LOCKOUT;
                    end
`endif
                end
            end
`ifdef DIV_KEY_LOCKOUT_EN
            LOCKOUT: state_d = LOCKOUT;
`endif
            default: state_d = LOCKED;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        mask     = key_reg_q[STAGES-1:0] ^ KEY[STAGES-1:0];
        unlocked = 1'b0;
        if (state_q == UNLOCKED) begin
            mask     = '0;
            unlocked = 1'b1;
        end else if (state_q == LOCKOUT) begin
            mask = '1;
        end
    end

`ifndef DIV_KEY_LOCKOUT_EN
    // Retry limit has no meaning without the lockout state
    logic unused_max_tries;
    assign unused_max_tries = ^MAX_TRIES;
`endif

    assign state    = state_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/locked_ripple_divider.sv
// Key-locked STAGES-bit divider: counter with XOR-corrupted increment, wrap pulse, divided output.
// Optional DIV_KEY_LOCKOUT_EN enables permanent lockout after MAX_TRIES wrong keys.
module locked_ripple_divider
    import locked_div_pkg::*;
#(
    parameter int               STAGES    = 4,
    parameter int               KEY_W     = 8,
    parameter logic [KEY_W-1:0] KEY       = 8'hA5,
    parameter int               MAX_TRIES = 3
) (
    input logic                   clk,
    input logic                   rst,
    locked_ripple_divider_if.slave bus
);

    lock_state_e       state;
    logic [STAGES-1:0] mask;
    logic [STAGES-1:0] count_q, count_d;
    logic              wrap_q, wrap_d;

    lock_key_fsm #(
        .STAGES    (STAGES),
        .KEY_W     (KEY_W),
        .KEY       (KEY),
        .MAX_TRIES (MAX_TRIES)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .key_in   (bus.key_in),
        .key_load (bus.key_load),
        .state    (state),
        .mask     (mask),
        .unlocked (bus.unlocked),
        .fail_cnt (bus.fail_cnt)
    );

    // Counter and wrap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Increment then scramble with the mask; wrap flags the step out of all-ones
    always_comb begin
        count_d = count_q;
        if (bus.en) begin
            count_d = (count_q + STAGES'(1)) ^ mask;
        end
        wrap_d = bus.en & (count_q == {STAGES{1'b1}});
    end

    logic unused_state;
    assign unused_state = ^state;

    assign bus.count   = count_q;
    assign bus.div_out = count_q[STAGES-1];
    assign bus.wrap    = wrap_q;

endmodule
